mesm6_vga_plot: RTL

Pixel-plot / horizontal-span engine that sits directly upstream of the MESM-6 4-plane 320x240 VGA adapter and drives its register bus (ADDRL=7, PLANE=6, DATA=0) as a bus master. The CPU loads X, Y, COLOR and LEN, then writes CMD. The engine performs read-modify-write of one bit in each of the four planes for each pixel of the span, which frees the CPU from plane and bit arithmetic.

---
 rtl/mesm6_vga_plot.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mesm6_vga_plot.sv
// Pixel-plot / horizontal-span engine: read-modify-writes one bit per plane per pixel
// on the MESM-6 4-plane VGA adapter register bus, acting as a bus master.
module mesm6_vga_plot #(
   parameter logic [14:0] VGA_BASE = 15'o0,
   parameter int          SCR_W    = 320,
   parameter int          SCR_H    = 240
) (
   input  logic        clk,
   input  logic        reset,
   output logic        interrupt,
   input  logic [14:0] i_addr,
   input  logic        i_rd,
   input  logic        i_wr,
   input  logic [47:0] i_wdata,
   output logic [47:0] o_rdata,
   output logic        o_done,
   output logic [14:0] m_addr,
   output logic        m_rd,
   output logic        m_wr,
   output logic [47:0] m_wdata,
   input  logic [47:0] m_rdata,
   input  logic        m_done
);

   localparam logic [2:0] REG_DATA  = 3'd0;
   localparam logic [2:0] REG_PLANE = 3'd6;
   localparam logic [2:0] REG_ADDRL = 3'd7;
   localparam logic [8:0] LP_W      = 9'(SCR_W);
   localparam logic [8:0] LP_H      = 9'(SCR_H);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_ADDR1, S_PLANE, S_READ, S_ADDR2, S_WRITE, S_NEXT, S_FIN
   } state_t;

   // CPU-visible registers
   logic [8:0]  r_x;
   logic [7:0]  r_y;
   logic [3:0]  r_color;
   logic [8:0]  r_len;
   logic        r_busy;
   logic        r_clip;
   logic        r_irq;
   logic        r_done;
   logic [47:0] r_rdata;

   // Command engine state
   state_t      r_state;
   logic [8:0]  r_cx;
   logic [7:0]  r_cy;
   logic [8:0]  r_count;
   logic [1:0]  r_p;
   logic [13:0] r_a;
   logic [2:0]  r_b;
   logic [7:0]  r_d;
   logic        r_req;

   // Master bus outputs
   logic [14:0] r_m_addr;
   logic        r_m_rd;
   logic        r_m_wr;
   logic [13:0] r_m_wdata;

   logic        w_wr_stb;
   logic        w_rd_stb;
   logic [47:0] w_rd_data;
   logic [13:0] w_pix_addr;
   logic [7:0]  w_new_byte;
   logic        w_bus_wr;
   logic [2:0]  w_bus_reg;
   logic [13:0] w_bus_data;
   state_t      w_bus_next;
   logic        w_unused;

   assign w_wr_stb   = i_wr & ~r_done;
   assign w_rd_stb   = i_rd & ~r_done;
   assign w_pix_addr = ({6'b0, r_cy} * 14'd40) + {8'b0, r_cx[8:3]};
   assign w_unused   = &{1'b0, i_addr[14:3], i_wdata[47:9], m_rdata[47:8]};

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_new_byte        = r_d;
      w_new_byte[r_b]   = r_color[r_p];
   end

   always_comb begin
      w_rd_data = '0;
      case (i_addr[2:0])
         3'd0:    w_rd_data = {39'b0, r_x};
         3'd1:    w_rd_data = {40'b0, r_y};
         3'd2:    w_rd_data = {44'b0, r_color};
         3'd3:    w_rd_data = {39'b0, r_len};
         3'd5:    w_rd_data = {46'b0, r_clip, r_busy};
         default: w_rd_data = '0;
      endcase
   end

   // Bus transaction described by each bus state, and the state that follows it
   always_comb begin
      w_bus_wr   = 1'b1;
      w_bus_reg  = REG_DATA;
      w_bus_data = '0;
      w_bus_next = r_state;
      case (r_state)
         S_ADDR1: begin
            w_bus_reg  = REG_ADDRL;
            w_bus_data = r_a;
            w_bus_next = S_PLANE;
         end
         S_PLANE: begin
            w_bus_reg  = REG_PLANE;
            w_bus_data = {12'b0, r_p};
            w_bus_next = S_READ;
         end
         S_READ: begin
            w_bus_wr   = 1'b0;
            w_bus_next = S_ADDR2;
         end
         // The adapter auto-increments its address on the DATA read, so it is reloaded.
         S_ADDR2: begin
            w_bus_reg  = REG_ADDRL;
            w_bus_data = r_a;
            w_bus_next = S_WRITE;
         end
         S_WRITE: begin
            w_bus_data = {6'b0, w_new_byte};
            w_bus_next = S_NEXT;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x       <= '0;
         r_y       <= '0;
         r_color   <= '0;
         r_len     <= '0;
         r_busy    <= 1'b0;
         r_clip    <= 1'b0;
         r_irq     <= 1'b0;
         r_done    <= 1'b0;
         r_rdata   <= '0;
         r_state   <= S_IDLE;
         r_cx      <= '0;
         r_cy      <= '0;
         r_count   <= '0;
         r_p       <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_d       <= '0;
         r_req     <= 1'b0;
         r_m_addr  <= VGA_BASE;
         r_m_rd    <= 1'b0;
         r_m_wr    <= 1'b0;
         r_m_wdata <= '0;
      end else begin
         r_done <= i_rd | i_wr;

         if (w_rd_stb) begin
            r_rdata <= w_rd_data;
            if (i_addr[2:0] == 3'd5) begin
               r_irq  <= 1'b0;
               r_clip <= 1'b0;
            end
         end

         if (w_wr_stb && !r_busy) begin
            case (i_addr[2:0])
               3'd0:    r_x     <= i_wdata[8:0];
               3'd1:    r_y     <= i_wdata[7:0];
               3'd2:    r_color <= i_wdata[3:0];
               3'd3:    r_len   <= i_wdata[8:0];
               default: ;
            endcase
         end

         // Engine updates come after the STATUS clear so a coinciding completion wins.
         case (r_state)
            S_IDLE: begin
               if (w_wr_stb && i_addr[2:0] == 3'd4) begin
                  r_cx    <= r_x;
                  r_cy    <= r_y;
                  r_count <= (r_len == 9'd0) ? 9'd1 : r_len;
                  r_p     <= 2'd0;
                  r_busy  <= 1'b1;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (r_cx >= LP_W || {1'b0, r_cy} >= LP_H) begin
                  r_clip  <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_a     <= w_pix_addr;
                  r_b     <= ~r_cx[2:0];
                  r_state <= S_ADDR1;
               end
            end
            S_ADDR1, S_PLANE, S_READ, S_ADDR2, S_WRITE: begin
               if (!r_req) begin
                  // Gap: the slave masks strobes while done is high, so wait for it to drop.
                  if (!m_done) begin
                     r_m_addr  <= VGA_BASE | {12'b0, w_bus_reg};
                     r_m_wdata <= w_bus_wr ? w_bus_data : 14'd0;
                     r_m_rd    <= ~w_bus_wr;
                     r_m_wr    <= w_bus_wr;
                     r_req     <= 1'b1;
                  end
               end else if (m_done) begin
                  r_m_rd  <= 1'b0;
                  r_m_wr  <= 1'b0;
                  r_req   <= 1'b0;
                  r_state <= w_bus_next;
                  if (r_state == S_READ)
                     r_d <= m_rdata[7:0];
               end
            end
            S_NEXT: begin
               if (r_p != 2'd3) begin
                  r_p     <= r_p + 2'd1;
                  r_state <= S_ADDR1;
               end else begin
                  r_p     <= 2'd0;
                  r_count <= r_count - 9'd1;
                  r_cx    <= r_cx + 9'd1;
                  // Span stops at the right screen edge without flagging clip.
                  if (r_count == 9'd1 || (r_cx + 9'd1) == LP_W)
                     r_state <= S_FIN;
                  else
                     r_state <= S_CHECK;
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_irq   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign interrupt = r_irq;
   assign o_done    = r_done;
   assign o_rdata   = r_rdata;
   assign m_addr    = r_m_addr;
   assign m_rd      = r_m_rd;
   assign m_wr      = r_m_wr;
   assign m_wdata   = {34'b0, r_m_wdata};

endmodule
